median_window_gen: RTL and testbench
====================================

# median_window_gen

- Sits directly upstream of the 3×3 median sorter.
- Takes the raster-order pixel stream read out of the image RAM.
- Buffers two previous lines and emits one fully populated 3×3 neighbourhood per accepted pixel once enough context exists.
- Border pixels produce no window; the downstream filter sees only (IMG_H-2)×(IMG_W-2) windows per frame.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 64, pixels per line (≥3)
- IMG_H, 64, lines per frame (≥3)
- clka  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  pix_in valid this cycle; low = stall, no state change
- sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame
- win  out  9*DATA_W  window; win[DATA_W*k +: DATA_W], k=3*i+j, i=row offset (0=top), j=col offset (0=left)
- win_valid  out  1  win/cen_row/cen_col valid, single-cycle per window
- cen_row  out  clog2(IMG_H)  row of window centre
- cen_col  out  clog2(IMG_W)  column of window centre
- done  out  1  one-cycle pulse, frame complete

## Operation
- Counters: col (0..IMG_W-1), row (0..IMG_H-1), advance only on pix_valid; col wraps to 0 and row increments at IMG_W-1; row wraps to 0 after (IMG_H-1, IMG_W-1).
- sof with pix_valid forces the pixel to be (0,0), regardless of counter state (mid-frame resync); counters continue from (0,1).
- Line buffers: two IMG_W-deep delay lines (register array or inferred RAM). On each accepted pixel, LB0 outputs the pixel of the previous row at the same column and LB1 the pixel two rows back; both write-shift. No reset needed on buffer contents.
- Window registers: 3×3 array shifts left one column per accepted pixel; new right column = {LB1 out, LB0 out, pix_in} for rows i=0,1,2.
- Window emitted for accepted pixel (r,c) iff r≥2 and c≥2; centre = (r-1, c-1); win[DATA_W*8 +: DATA_W] = pixel (r,c), win[0 +: DATA_W] = pixel (r-2,c-2).
- FSM:
  - S_FILL: row<2; no windows; → S_RUN on first pixel of row 2.
  - S_RUN: emit per rule above; → S_DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
  - S_DONE: done=1 for one cycle; → S_FILL unconditionally. A pix_valid in this cycle is accepted as (0,0) of the next frame.
  - sof in any state → S_FILL with counters reset.
- Window columns spanning a line wrap (c=0,1) contain stale data and are never emitted.

## Timing
- Reset values: win=0, win_valid=0, cen_row=0, cen_col=0, done=0, state=S_FILL, counters=0.
- Latency: pixel accepted in cycle N → win_valid in cycle N+1 (registered outputs). done asserts in the same cycle as the final win_valid.
- Throughput: one pixel per cycle sustained; no backpressure. Downstream must accept every win_valid.
- Stalls: pix_valid=0 holds counters, buffers, and window; win_valid=0 next cycle, while win/cen_* hold their last values.
- Reset mid-frame: all outputs to reset values immediately (async); next accepted pixel is (0,0) with or without sof.
- sof and last-pixel coincident: sof wins; no done pulse.

## Test plan
Parameters: IMG_W=8, IMG_H=6. Pixel value = row*16+col.

- Continuous ramp frame, sof on first pixel:
  - First win_valid one cycle after pixel (2,2): cen=(1,1), win k0=0x00, k4=0x11, k8=0x22.
  - Exactly 24 win_valid pulses.
  - done coincident with last window, centre (4,6), k8=0x57.
- Random pix_valid gaps (~40% duty): same 24 windows with identical contents and order; win_valid never asserts in the cycle after an idle input cycle; single done pulse.
- Reset (0 for 2 cycles) after pixel (3,4):
  - Outputs immediately zero.
  - Fresh frame yields 24 correct windows with no stale data.
  - Check first window k0=0x00.
- sof reasserted after pixel (4,2):
  - No done for the aborted frame.
  - Restarted frame produces 24 correct windows, first at cen=(1,1).
- Two back-to-back frames, pix_valid continuous with pixel (0,0) of frame 2 in the S_DONE cycle:
  - 48 windows total, two done pulses.
  - Frame 2 first window k4=0x11.
- Minimum size IMG_W=3, IMG_H=3: exactly one window, cen=(1,1), with done on the same cycle.

Source files
------------

// File: rtl/median_window_gen_if.sv
// Raster pixel stream in, 3x3 neighbourhood stream out, for median_window_gen.
// The producer side takes the master view; the window generator takes the slave view.
interface median_window_gen_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [DATA_W-1:0]   pix_in;
  logic                pix_valid;
  logic                sof;
  logic [9*DATA_W-1:0] win;
  logic                win_valid;
  logic [ROW_W-1:0]    cen_row;
  logic [COL_W-1:0]    cen_col;
  logic                done;

  modport master (
    output pix_in, pix_valid, sof,
    input  win, win_valid, cen_row, cen_col, done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output win, win_valid, cen_row, cen_col, done
  );
endinterface

// File: rtl/median_window_gen.sv
// Two-line-buffer 3x3 window generator feeding the median sorter: one window per
// accepted interior pixel, centre one row and one column behind the newest pixel.
module median_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input logic                clka,
  input logic                reset,
  median_window_gen_if.slave bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] pix_t;

  state_t              state, state_next;
  logic [ROW_W-1:0]    row, pix_row, row_next;
  logic [COL_W-1:0]    col, pix_col, col_next;
  logic                accept;
  logic                restart;
  logic                last_pix;
  logic                emit;

  pix_t                lb0 [IMG_W];
  pix_t                lb1 [IMG_W];
  pix_t                lb0_rd, lb1_rd;
  pix_t                win_r  [3][3];
  pix_t                win_nx [3][3];
  logic [9*DATA_W-1:0] win_flat;

  // Coordinates of the pixel on the bus: sof, or the cycle after a frame's last
  // pixel, pins it to (0,0) whatever the counters say.
  assign accept   = bus.pix_valid;
  assign restart  = bus.sof || (state == S_DONE);
  assign pix_row  = restart ? '0 : row;
  assign pix_col  = restart ? '0 : col;
  assign last_pix = (pix_row == ROW_LAST) && (pix_col == COL_LAST);

  // Indexing by column gives "same column, previous row" even after a resync.
  assign lb0_rd = lb0[pix_col];
  assign lb1_rd = lb1[pix_col];

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    col_next = pix_col + COL_ONE;
    row_next = pix_row;
    if (pix_col == COL_LAST) begin
      col_next = '0;
      row_next = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_ONE;
    end
  end

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    unique case (state)
      S_FILL: begin
        if (accept && !bus.sof && (pix_row == ROW_TWO)) state_next = S_RUN;
      end
      S_RUN: begin
        if (accept && !bus.sof) begin
          emit = (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
          if (last_pix) state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_FILL;
      end
      default: begin
        state_next = S_FILL;
      end
    endcase
    if (accept && bus.sof) state_next = S_FILL;
  end

  always_ff @(posedge clka or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (!reset) state <= S_FILL;
    else        state <= state_next;
  end

  // Window shifts left; the new right column is {two rows back, one row back, current}.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_nx[i][0] = win_r[i][1];
      win_nx[i][1] = win_r[i][2];
      win_nx[i][2] = '0;
    end
    win_nx[0][2] = lb1_rd;
    win_nx[1][2] = lb0_rd;
    win_nx[2][2] = bus.pix_in;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat[DATA_W*(3*i+j) +: DATA_W] = win_nx[i][j];
      end
    end
  end

  // NOTE: line buffers and the window array carry no reset; every emitted
  // window is rebuilt from pixels of the current frame before it is used.
  always_ff @(posedge clka) begin
    if (accept) begin
      lb0[pix_col] <= bus.pix_in;
      lb1[pix_col] <= lb0_rd;
      win_r        <= win_nx;
    end
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      row           <= '0;
      col           <= '0;
      bus.win       <= '0;
      bus.win_valid <= 1'b0;
      bus.cen_row   <= '0;
      bus.cen_col   <= '0;
    end else begin
      bus.win_valid <= emit;
      if (accept) begin
        row <= row_next;
        col <= col_next;
      end
      if (emit) begin
        bus.win     <= win_flat;
        bus.cen_row <= pix_row - ROW_ONE;
        bus.cen_col <= pix_col - COL_ONE;
      end
    end
  end

  // S_DONE lasts exactly one cycle, so done is a single-cycle pulse.
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen: raster frames with random gaps and data, compared
// against windows cut straight out of a 2-D image array.
module tb_median_window_gen;
  localparam int DW   = 8;
  localparam int MW   = 8;
  localparam int MH   = 6;
  localparam int NPIX = MW * MH;
  localparam int NWIN = (MW - 2) * (MH - 2);

  typedef struct {
    logic [9*DW-1:0] win;
    logic [2:0]      row;
    logic [2:0]      col;
    logic            done;
  } win_t;

  logic clka  = 1'b0;
  logic reset = 1'b0;
  always #5 clka = ~clka;

  median_window_gen_if #(.DATA_W(DW), .IMG_W(MW), .IMG_H(MH)) bus ();
  median_window_gen_if #(.DATA_W(DW), .IMG_W(3),  .IMG_H(3))  sbus ();

  median_window_gen #(.DATA_W(DW), .IMG_W(MW), .IMG_H(MH)) dut (
    .clka (clka),
    .reset(reset),
    .bus  (bus)
  );

  median_window_gen #(.DATA_W(DW), .IMG_W(3), .IMG_H(3)) dut_min (
    .clka (clka),
    .reset(reset),
    .bus  (sbus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  int   idle_viol   = 0;
  logic prev_pv     = 1'b0;
  win_t obs_q[$];
  win_t exp_q[$];
  logic [7:0] img [MH][MW];

  int              s_wv_cnt   = 0;
  int              s_done_cnt = 0;
  logic [9*DW-1:0] s_win      = '0;
  logic [1:0]      s_row      = '0;
  logic [1:0]      s_col      = '0;
  logic            s_done_wv  = 1'b0;

  always @(negedge clka) begin
    if (bus.win_valid === 1'b1) obs_q.push_back('{bus.win, bus.cen_row, bus.cen_col, bus.done});
    if (bus.done === 1'b1) done_cnt++;
    if (bus.win_valid === 1'b1 && prev_pv !== 1'b1) idle_viol++;
    prev_pv = bus.pix_valid;
    if (sbus.win_valid === 1'b1) begin
      s_wv_cnt++;
      s_win     = sbus.win;
      s_row     = sbus.cen_row;
      s_col     = sbus.cen_col;
      s_done_wv = sbus.done;
    end
    if (sbus.done === 1'b1) s_done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] p, input logic s, input int idle_pct);
    int n;
    n = 0;
    while (n < 6 && int'($urandom_range(99)) < idle_pct) begin
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      tick();
      n++;
    end
    bus.pix_in    = p;
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int sof_idx, input int idle_pct);
    for (int n = first; n <= last; n++) send_pixel(img[n / MW][n % MW], n == sof_idx, idle_pct);
  endtask

  task automatic drain();
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_cnt  = 0;
    idle_viol = 0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++) img[r][c] = 8'(r * 16 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++) img[r][c] = 8'($urandom_range(255));
  endtask

  // Every interior pixel (r,c) of the image yields the 3x3 block ending at it.
  task automatic build_expected(input bit append);
    win_t e;
    if (!append) exp_q.delete();
    for (int r = 2; r < MH; r++) begin
      for (int c = 2; c < MW; c++) begin
        e.win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) e.win[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
        e.row  = 3'(r - 1);
        e.col  = 3'(c - 1);
        e.done = (r == MH - 1) && (c == MW - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (bus.win !== '0 || bus.win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_win: got win=%h valid=%b want 0/0", bus.win, bus.win_valid);
    end
    vectors++;
    if (bus.cen_row !== 3'd0 || bus.cen_col !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_cen: got (%0d,%0d) want (0,0)", bus.cen_row, bus.cen_col);
    end
    vectors++;
    if (bus.done !== 1'b0 || sbus.done !== 1'b0 || sbus.win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b/%b/%b want 0/0/0", bus.done, sbus.done, sbus.win_valid);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ramp_frame();
    clear_obs();
    fill_ramp();
    build_expected(1'b0);
    send_range(0, NPIX - 1, 0, 0);
    drain();
    vectors++;
    if (obs_q.size() != NWIN) begin
      miscompares++;
      $display("FAIL ramp_count: got %0d want %0d", obs_q.size(), NWIN);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL ramp_done_cnt: got %0d want 1", done_cnt);
    end
    if (obs_q.size() > 0) begin
      vectors++;
      if (obs_q[0].row !== 3'd1 || obs_q[0].col !== 3'd1 || obs_q[0].win[7:0] !== 8'h00 ||
          obs_q[0].win[39:32] !== 8'h11 || obs_q[0].win[71:64] !== 8'h22) begin
        miscompares++;
        $display("FAIL ramp_first: got cen=(%0d,%0d) k0=%h k4=%h k8=%h want (1,1) 00 11 22",
                 obs_q[0].row, obs_q[0].col, obs_q[0].win[7:0], obs_q[0].win[39:32], obs_q[0].win[71:64]);
      end
      vectors++;
      if (obs_q[$].done !== 1'b1 || obs_q[$].row !== 3'd4 || obs_q[$].col !== 3'd6 ||
          obs_q[$].win[71:64] !== 8'h57) begin
        miscompares++;
        $display("FAIL ramp_last: got done=%b cen=(%0d,%0d) k8=%h want 1 (4,6) 57",
                 obs_q[$].done, obs_q[$].row, obs_q[$].col, obs_q[$].win[71:64]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL ramp_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL ramp_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_random_gaps();
    clear_obs();
    fill_ramp();
    build_expected(1'b0);
    send_range(0, NPIX - 1, 0, 40);
    drain();
    vectors++;
    if (obs_q.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL gaps_count: got %0d windows %0d done want %0d 1", obs_q.size(), done_cnt, NWIN);
    end
    vectors++;
    if (idle_viol != 0) begin
      miscompares++;
      $display("FAIL gaps_idle_valid: got %0d windows after idle cycles want 0", idle_viol);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL gaps_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL gaps_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    fill_ramp();
    send_range(0, 3 * MW + 4, 0, 0);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.win !== '0 || bus.win_valid !== 1'b0 || bus.cen_row !== 3'd0 ||
        bus.cen_col !== 3'd0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got win=%h v=%b cen=(%0d,%0d) done=%b want all 0",
               bus.win, bus.win_valid, bus.cen_row, bus.cen_col, bus.done);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_obs();
    build_expected(1'b0);
    send_range(0, NPIX - 1, -1, 0);
    drain();
    vectors++;
    if (obs_q.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d windows %0d done want %0d 1", obs_q.size(), done_cnt, NWIN);
    end
    if (obs_q.size() > 0) begin
      vectors++;
      if (obs_q[0].win[7:0] !== 8'h00) begin
        miscompares++;
        $display("FAIL midreset_k0: got %h want 00", obs_q[0].win[7:0]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL midreset_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL midreset_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_sof_resync();
    clear_obs();
    fill_ramp();
    send_range(0, 4 * MW + 2, 0, 0);
    drain();
    vectors++;
    if (done_cnt != 0 || obs_q.size() != 13) begin
      miscompares++;
      $display("FAIL resync_aborted: got %0d windows %0d done want 13 0", obs_q.size(), done_cnt);
    end
    clear_obs();
    build_expected(1'b0);
    send_range(0, NPIX - 1, 0, 20);
    drain();
    vectors++;
    if (obs_q.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL resync_count: got %0d windows %0d done want %0d 1", obs_q.size(), done_cnt, NWIN);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL resync_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL resync_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_sof_on_last();
    clear_obs();
    fill_ramp();
    send_range(0, NPIX - 2, 0, 0);
    send_pixel(img[MH-1][MW-1], 1'b1, 0);
    drain();
    vectors++;
    if (obs_q.size() != NWIN - 1 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL soflast_aborted: got %0d windows %0d done want %0d 0", obs_q.size(), done_cnt, NWIN - 1);
    end
    clear_obs();
    img[0][0] = img[MH-1][MW-1];
    build_expected(1'b0);
    send_range(1, NPIX - 1, -1, 0);
    drain();
    vectors++;
    if (obs_q.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL soflast_count: got %0d windows %0d done want %0d 1", obs_q.size(), done_cnt, NWIN);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL soflast_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL soflast_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    fill_ramp();
    build_expected(1'b0);
    build_expected(1'b1);
    send_range(0, NPIX - 1, 0, 0);
    send_range(0, NPIX - 1, -1, 0);
    drain();
    vectors++;
    if (obs_q.size() != 2 * NWIN || done_cnt != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d windows %0d done want %0d 2", obs_q.size(), done_cnt, 2 * NWIN);
    end
    if (obs_q.size() > NWIN) begin
      vectors++;
      if (obs_q[NWIN].win[39:32] !== 8'h11) begin
        miscompares++;
        $display("FAIL b2b_frame2_k4: got %h want 11", obs_q[NWIN].win[39:32]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size()) begin
        miscompares++;
        $display("FAIL b2b_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
      end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                   obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
        miscompares++;
        $display("FAIL b2b_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                 obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
      end
    end
  endtask

  task automatic test_random_pixels();
    for (int f = 0; f < 3; f++) begin
      clear_obs();
      fill_random();
      build_expected(1'b0);
      send_range(0, NPIX - 1, (f == 0) ? 0 : -1, 25);
      drain();
      vectors++;
      if (obs_q.size() != NWIN || done_cnt != 1) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: got %0d windows %0d done want %0d 1", f, obs_q.size(), done_cnt, NWIN);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (i >= obs_q.size()) begin
          miscompares++;
          $display("FAIL rand_win[%0d]: got none want cen=(%0d,%0d)", i, exp_q[i].row, exp_q[i].col);
        end else if (obs_q[i].win !== exp_q[i].win || obs_q[i].row !== exp_q[i].row ||
                     obs_q[i].col !== exp_q[i].col || obs_q[i].done !== exp_q[i].done) begin
          miscompares++;
          $display("FAIL rand_win[%0d]: got (%0d,%0d) d=%b %h want (%0d,%0d) d=%b %h", i, obs_q[i].row,
                   obs_q[i].col, obs_q[i].done, obs_q[i].win, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].win);
        end
      end
    end
  endtask

  task automatic test_min_size();
    logic [9*DW-1:0] exp_w;
    exp_w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) exp_w[DW*(3*i+j) +: DW] = 8'(i * 16 + j);
    for (int n = 0; n < 9; n++) begin
      sbus.pix_in    = 8'((n / 3) * 16 + (n % 3));
      sbus.sof       = (n == 0);
      sbus.pix_valid = 1'b1;
      tick();
    end
    sbus.pix_valid = 1'b0;
    sbus.sof       = 1'b0;
    repeat (4) tick();
    vectors++;
    if (s_wv_cnt != 1 || s_done_cnt != 1) begin
      miscompares++;
      $display("FAIL min_count: got %0d windows %0d done want 1 1", s_wv_cnt, s_done_cnt);
    end
    vectors++;
    if (s_row !== 2'd1 || s_col !== 2'd1 || s_done_wv !== 1'b1) begin
      miscompares++;
      $display("FAIL min_cen: got (%0d,%0d) done=%b want (1,1) done=1", s_row, s_col, s_done_wv);
    end
    vectors++;
    if (s_win !== exp_w) begin
      miscompares++;
      $display("FAIL min_win: got %h want %h", s_win, exp_w);
    end
  endtask

  initial begin
    bus.pix_in     = '0;
    bus.pix_valid  = 1'b0;
    bus.sof        = 1'b0;
    sbus.pix_in    = '0;
    sbus.pix_valid = 1'b0;
    sbus.sof       = 1'b0;
    test_reset();
    test_ramp_frame();
    test_random_gaps();
    test_reset_mid_frame();
    test_sof_resync();
    test_sof_on_last();
    test_back_to_back();
    test_random_pixels();
    test_min_size();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
